// File: rtl/cordic_iter_if.sv
// cordic_iter_if: operand/result handshake bundle for cordic_iter.
// The master drives operands and out_ready. The slave (core) drives in_ready, the results and busy.
interface cordic_iter_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic signed [WIDTH-1:0] in_x;
  logic signed [WIDTH-1:0] in_y;
  logic signed [WIDTH-1:0] in_z;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_x;
  logic signed [WIDTH-1:0] out_y;
  logic signed [WIDTH-1:0] out_z;
  logic                    busy;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, busy
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, busy
  );
endinterface

// File: rtl/cordic_iter.sv
// cordic_iter: iterative CORDIC core. Each op selects rotation or vectoring mode, and the core does one micro-rotation per clock.
// Defining CORDIC_GAIN_COMP_EN adds a GAIN state that scales x/y by ~1/K before output rounding.
module cordic_iter #(
  parameter int WIDTH = 16,
  parameter int ITER  = 14,
  parameter int GUARD = 2
) (
  input logic          clk,
  input logic          rst,
  cordic_iter_if.slave io
);
  localparam int IW = WIDTH + GUARD;
  localparam int FB = IW - 2;
  // Two integer headroom bits keep gain growth, pre-rotation and vectoring angles from wrapping before saturation.
  localparam int DW = IW + 2;
  localparam int CW = $clog2(ITER + 1);
  localparam int SB = 60;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROT  = 2'd1;
  localparam logic [1:0] S_GAIN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // atan(1/n) scaled by 2^SB, from the alternating Taylor series.
  function automatic longint atan_inv(input longint n);
    longint p;
    longint s;
    s = 0;
    p = (longint'(1) << SB) / n;
    for (int unsigned k = 0; k < 40; k++) begin
      if (k[0]) s = s - p / longint'(2 * k + 1);
      else      s = s + p / longint'(2 * k + 1);
      p = p / (n * n);
    end
    return s;
  endfunction

  function automatic longint fix_round(input longint v);
    return (v + (longint'(1) << (SB - FB - 1))) >>> (SB - FB);
  endfunction

  // The i == 0 entry uses Machin's formula (pi/4), because the series converges too slowly at n == 1.
  function automatic longint atan_fix(input int unsigned i);
    if (i == 0) return fix_round(4 * atan_inv(5) - atan_inv(239));
    return fix_round(atan_inv(longint'(1) << i));
  endfunction

  localparam logic signed [DW-1:0] HALF_PI = DW'(fix_round(8 * atan_inv(5) - 2 * atan_inv(239)));
  localparam logic signed [DW:0]   RND     = (DW+1)'((2 ** GUARD) / 2);
  localparam logic signed [DW:0]   SAT_HI  = (DW+1)'(2 ** (WIDTH - 1) - 1);

  function automatic logic signed [WIDTH-1:0] to_out(input logic signed [DW-1:0] v);
    logic signed [DW:0] r;
    r = ((DW+1)'(v) + RND) >>> GUARD;
    if (r > SAT_HI)       r = SAT_HI;
    else if (r < -SAT_HI) r = -SAT_HI;
    return WIDTH'(r);
  endfunction

  logic signed [DW-1:0] atan_tab [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic signed [DW-1:0] ANG = DW'(atan_fix(g));
    assign atan_tab[g] = ANG;
  end

  logic [1:0]              state;
  logic                    rdy_en;
  logic                    mode;
  logic [CW-1:0]           iter;
  logic signed [DW-1:0]    x, y, z;
  logic signed [DW-1:0]    ext_x, ext_y, ext_z;
  logic signed [DW-1:0]    pre_x, pre_y, pre_z;
  logic signed [DW-1:0]    atan_cur, x_nxt, y_nxt, z_nxt;
  logic signed [DW-1:0]    x_fin, y_fin;
  logic signed [WIDTH-1:0] out_x_r, out_y_r, out_z_r;
  logic                    dir_pos;
  logic                    accept;

  assign io.in_ready  = (state == S_IDLE) && rdy_en;
  assign io.out_valid = (state == S_DONE);
  assign io.busy      = (state != S_IDLE);
  assign io.out_x     = out_x_r;
  assign io.out_y     = out_y_r;
  assign io.out_z     = out_z_r;
  assign accept       = io.in_valid && io.in_ready;

  // Quadrant pre-rotation brings the operand into CORDIC's +-pi/2 convergence range.
  always_comb begin
    ext_x = DW'(io.in_x) <<< GUARD;
    ext_y = DW'(io.in_y) <<< GUARD;
    ext_z = io.in_mode ? '0 : (DW'(io.in_z) <<< GUARD);
    pre_x = ext_x;
    pre_y = ext_y;
    pre_z = ext_z;
    if (!io.in_mode) begin
      if (ext_z > HALF_PI) begin
        pre_x = -ext_y;
        pre_y = ext_x;
        pre_z = ext_z - HALF_PI;
      end else if (ext_z < -HALF_PI) begin
        pre_x = ext_y;
        pre_y = -ext_x;
        pre_z = ext_z + HALF_PI;
      end
    end else if (ext_x[DW-1]) begin
      if (!ext_y[DW-1]) begin
        pre_x = ext_y;
        pre_y = -ext_x;
        pre_z = HALF_PI;
      end else begin
        pre_x = -ext_y;
        pre_y = ext_x;
        pre_z = -HALF_PI;
      end
    end
  end

  always_comb begin
    atan_cur = '0;
    for (int unsigned k = 0; k < ITER; k++) begin
      if (iter == CW'(k)) atan_cur = atan_tab[k];
    end
    dir_pos = mode ? y[DW-1] : !z[DW-1];
    x_nxt   = dir_pos ? x - (y >>> iter) : x + (y >>> iter);
    y_nxt   = dir_pos ? y + (x >>> iter) : y - (x >>> iter);
    z_nxt   = dir_pos ? z - atan_cur : z + atan_cur;
  end

`ifdef CORDIC_GAIN_COMP_EN
  function automatic logic signed [DW-1:0] inv_gain(input logic signed [DW-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 13);
  endfunction
  assign x_fin = inv_gain(x);
  assign y_fin = inv_gain(y);
`else
  assign x_fin = x;
  assign y_fin = y;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rdy_en  <= 1'b0;
      mode    <= 1'b0;
      iter    <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      out_x_r <= '0;
      out_y_r <= '0;
      out_z_r <= '0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_ROT;
            mode  <= io.in_mode;
            iter  <= '0;
            x     <= pre_x;
            y     <= pre_y;
            z     <= pre_z;
          end
        end
        S_ROT: begin
          if (iter == CW'(ITER)) begin
`ifdef CORDIC_GAIN_COMP_EN
            state   <= S_GAIN;
`else
            state   <= S_DONE;
            out_x_r <= to_out(x_fin);
            out_y_r <= to_out(y_fin);
            out_z_r <= to_out(z);
`endif
          end else begin
            x    <= x_nxt;
            y    <= y_nxt;
            z    <= z_nxt;
            iter <= iter + CW'(1);
          end
        end
        S_GAIN: begin
          state   <= S_DONE;
          out_x_r <= to_out(x_fin);
          out_y_r <= to_out(y_fin);
          out_z_r <= to_out(z);
        end
        S_DONE: begin
          if (io.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: vector table plus randomized ops for cordic_iter (WIDTH=16, ITER=14, GUARD=2).
// Random results are compared bit-exact against an arithmetic reference model; back-pressure and mid-op reset are directed sequences.
module tb_cordic_iter;
  localparam int WIDTH = 16;
  localparam int ITER  = 14;
  localparam int GUARD = 2;
  localparam int FB    = WIDTH + GUARD - 2;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 2;
`else
  localparam int LAT = ITER + 1;
`endif

  typedef struct {
    bit          mode;
    logic [15:0] x, y, z;
    logic [15:0] ex, ey, ez;
    int          tol;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_iter_if #(.WIDTH(WIDTH)) io ();
  cordic_iter #(.WIDTH(WIDTH), .ITER(ITER), .GUARD(GUARD)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tv [$];

  task automatic chk(input string name, input longint act, input longint exp, input int tol);
    longint d;
    n_cmp++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  function automatic longint fixq(input real r);
    return longint'($floor(r * (2.0 ** FB) + 0.5));
  endfunction

  function automatic longint rnd_sat(input longint v);
    longint r;
    r = (v + (longint'(1) << GUARD) / 2) >>> GUARD;
    if (r > 32767)  r = 32767;
    if (r < -32767) r = -32767;
    return r;
  endfunction

  // Reference: quadrant fold, then ITER textbook micro-rotations on plain integers.
  function automatic void model(input bit mode, input logic [15:0] ix, iy, iz,
                                output longint ox, oy, oz);
    longint x, y, z, t, hp, xs, ys, a;
    bit     dpos;
    hp = fixq(3.14159265358979 / 2.0);
    x  = longint'(signed'(ix)) <<< GUARD;
    y  = longint'(signed'(iy)) <<< GUARD;
    z  = mode ? 0 : (longint'(signed'(iz)) <<< GUARD);
    if (!mode) begin
      if (z > hp) begin t = x; x = -y; y = t; z = z - hp; end
      else if (z < -hp) begin t = x; x = y; y = -t; z = z + hp; end
    end else if (x < 0) begin
      if (y >= 0) begin t = x; x = y; y = -t; z = hp; end
      else begin t = x; x = -y; y = t; z = -hp; end
    end
    for (int i = 0; i < ITER; i++) begin
      a    = fixq($atan(2.0 ** (-i)));
      xs   = x >>> i;
      ys   = y >>> i;
      dpos = mode ? (y < 0) : (z >= 0);
      if (dpos) begin x = x - ys; y = y + xs; z = z - a; end
      else      begin x = x + ys; y = y - xs; z = z + a; end
    end
`ifdef CORDIC_GAIN_COMP_EN
    x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9) - (x >>> 13);
    y = (y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9) - (y >>> 13);
`endif
    ox = rnd_sat(x);
    oy = rnd_sat(y);
    oz = rnd_sat(z);
  endfunction

  task automatic do_op(input bit mode, input logic [15:0] x, y, z,
                       output logic signed [15:0] rx, ry, rz, output int lat);
    int n;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_mode  = mode;
    io.in_x     = x;
    io.in_y     = y;
    io.in_z     = z;
    n = 0;
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", io.in_ready, 1, 0);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!io.out_valid && lat < 100);
    rx = io.out_x;
    ry = io.out_y;
    rz = io.out_z;
  endtask

  task automatic release_out();
    @(negedge clk);
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] rx, ry, rz, r1x, r1y, r1z;
    longint             mx, my, mz;
    int                 lat;
    vec_t               v;
    bit                 m;
    logic [15:0]        ax, ay, az;

    io.in_valid  = 1'b0;
    io.in_mode   = 1'b0;
    io.in_x      = '0;
    io.in_y      = '0;
    io.in_z      = '0;
    io.out_ready = 1'b0;

    // Reset state.
    #2 rst = 1'b0;
    #10;
    chk("rst_in_ready", io.in_ready, 0, 0);
    chk("rst_out_valid", io.out_valid, 0, 0);
    chk("rst_busy", io.busy, 0, 0);
    chk("rst_out_x", io.out_x, 0, 0);
    chk("rst_out_y", io.out_y, 0, 0);
    chk("rst_out_z", io.out_z, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("in_ready_before_edge", io.in_ready, 0, 0);
    @(posedge clk);
    #1 chk("in_ready_first_edge", io.in_ready, 1, 0);

    // Baseline op: output latency and a bit-exact reference for the reset test.
    do_op(1'b0, 16'h26DD, 16'h0000, 16'h6488, r1x, r1y, r1z, lat);
    chk("t1_latency", lat, LAT, 0);
    model(1'b0, 16'h26DD, 16'h0000, 16'h6488, mx, my, mz);
    chk("t1_model_x", r1x, mx, 0);
    chk("t1_model_y", r1y, my, 0);
    chk("t1_model_z", r1z, mz, 0);
    release_out();

`ifdef CORDIC_GAIN_COMP_EN
    tv.push_back('{1'b0, 16'h4000, 16'h0000, 16'h3244, 16'h2D41, 16'h2D41, 16'h0000, 3});
    tv.push_back('{1'b0, 16'h26DD, 16'h0000, 16'h6488, 16'h0000, 16'h26DE, 16'h0000, 3});
    tv.push_back('{1'b1, 16'h2000, 16'h2000, 16'h0000, 16'h2D42, 16'h0000, 16'h3244, 3});
    tv.push_back('{1'b1, 16'hE000, 16'h2000, 16'h0000, 16'h2D42, 16'h0000, 16'h7FFF, 3});
    tv.push_back('{1'b0, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 8});
    tv.push_back('{1'b0, 16'h8000, 16'h0000, 16'h0000, 16'h8001, 16'h0000, 16'h0000, 8});
`else
    tv.push_back('{1'b0, 16'h26DD, 16'h0000, 16'h6488, 16'h0000, 16'h4000, 16'h0000, 3});
    tv.push_back('{1'b0, 16'h26DD, 16'h0000, 16'h9B78, 16'h0000, 16'hC000, 16'h0000, 3});
    tv.push_back('{1'b0, 16'h26DD, 16'h0000, 16'h7000, 16'hF498, 16'h3EFA, 16'h0000, 3});
    tv.push_back('{1'b0, 16'h26DD, 16'h0000, 16'h3244, 16'h2D41, 16'h2D41, 16'h0000, 3});
    tv.push_back('{1'b1, 16'h2000, 16'h2000, 16'h0000, 16'h4A86, 16'h0000, 16'h3244, 3});
    tv.push_back('{1'b1, 16'hE000, 16'h2000, 16'h0000, 16'h4A86, 16'h0000, 16'h7FFF, 3});
    tv.push_back('{1'b1, 16'hE000, 16'hE000, 16'h0000, 16'h4A86, 16'h0000, 16'h8001, 3});
    tv.push_back('{1'b1, 16'h4000, 16'h0000, 16'h0000, 16'h6964, 16'h0000, 16'h0000, 3});
    tv.push_back('{1'b0, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 8});
    tv.push_back('{1'b0, 16'h8000, 16'h0000, 16'h0000, 16'h8001, 16'h0000, 16'h0000, 8});
`endif
    for (int i = 0; i < tv.size(); i++) begin
      v = tv[i];
      do_op(v.mode, v.x, v.y, v.z, rx, ry, rz, lat);
      chk($sformatf("vec%0d_lat", i), lat, LAT, 0);
      chk($sformatf("vec%0d_x", i), rx, longint'(signed'(v.ex)), v.tol);
      chk($sformatf("vec%0d_y", i), ry, longint'(signed'(v.ey)), v.tol);
      chk($sformatf("vec%0d_z", i), rz, longint'(signed'(v.ez)), v.tol);
      release_out();
    end

    // Back-pressure: the result holds and new ops are ignored until out_ready.
    do_op(1'b0, 16'h26DD, 16'h0000, 16'h6488, rx, ry, rz, lat);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.in_x     = 16'h1234;
      io.in_z     = 16'h0100;
      chk("bp_out_valid", io.out_valid, 1, 0);
      chk("bp_out_x", io.out_x, rx, 0);
      chk("bp_out_y", io.out_y, ry, 0);
      chk("bp_out_z", io.out_z, rz, 0);
      chk("bp_in_ready", io.in_ready, 0, 0);
      chk("bp_busy", io.busy, 1, 0);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", io.out_valid, 0, 0);
    chk("bp_release_busy", io.busy, 0, 0);
    chk("bp_release_in_ready", io.in_ready, 1, 0);
    @(negedge clk);
    io.out_ready = 1'b0;

    // Reset during iteration 5 drops the op.
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_mode  = 1'b0;
    io.in_x     = 16'h26DD;
    io.in_y     = 16'h0000;
    io.in_z     = 16'h6488;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    chk("op_busy", io.busy, 1, 0);
    chk("op_in_ready", io.in_ready, 0, 0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", io.out_valid, 0, 0);
    chk("mid_rst_busy", io.busy, 0, 0);
    chk("mid_rst_in_ready", io.in_ready, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_result_after_rst", io.out_valid, 0, 0);
    do_op(1'b0, 16'h26DD, 16'h0000, 16'h6488, rx, ry, rz, lat);
    chk("rerun_latency", lat, LAT, 0);
    chk("rerun_x", rx, r1x, 0);
    chk("rerun_y", ry, r1y, 0);
    chk("rerun_z", rz, r1z, 0);
    release_out();

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      m  = 1'($urandom_range(0, 1));
      ax = 16'($urandom);
      ay = 16'($urandom);
      az = 16'($urandom);
      model(m, ax, ay, az, mx, my, mz);
      do_op(m, ax, ay, az, rx, ry, rz, lat);
      chk($sformatf("rnd%0d_lat", i), lat, LAT, 0);
      chk($sformatf("rnd%0d_x", i), rx, mx, 0);
      chk($sformatf("rnd%0d_y", i), ry, my, 0);
      chk($sformatf("rnd%0d_z", i), rz, mz, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
